bombe_rotor_stepper: RTL



---
 rtl/bombe_pkg.sv | 30 +++
 rtl/mod26_digit.sv | 37 +++
 rtl/bombe_rotor_stepper.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/bombe_pkg.sv
// Shared constants, state encoding and helpers for the bombe rotor stepper.
// Positions are mod-26 digits; the search covers 26^3 rotor positions.
package bombe_pkg;

  localparam int ROTOR_W = 5;
  localparam int CNT_W   = 15;
  localparam int TOTAL_POSITIONS = 17576;

  localparam logic [ROTOR_W-1:0] ROTOR_MAX = ROTOR_W'(25);
  localparam logic [CNT_W-1:0]   LAST_IDX  =
    CNT_W'(TOTAL_POSITIONS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_TEST   = 3'd3,
    ST_STEP   = 3'd4,
    ST_FOUND  = 3'd5,
    ST_EXH    = 3'd6
  } state_e;

  // Out-of-range start positions fall back to 0.
  function automatic logic [ROTOR_W-1:0] clamp_init(
    input logic [ROTOR_W-1:0] v
  );
    return (v > ROTOR_MAX) ? '0 : v;
  endfunction

endpackage

// File: rtl/mod26_digit.sv
// One mod-26 position digit: load, carry-gated increment, 25->0 wrap.
// Ports: clk, resetn, load/load_val, step, cin in; q, cout out.
module mod26_digit
  import bombe_pkg::*;
(
  input  logic               clk,
  input  logic               resetn,
  input  logic               load,
  input  logic [ROTOR_W-1:0] load_val,
  input  logic               step,
  input  logic               cin,
  output logic [ROTOR_W-1:0] q,
  output logic               cout
);

  logic [ROTOR_W-1:0] q_q;
  logic [ROTOR_W-1:0] q_d;

  // Carry out means "this digit wraps if it steps".
  assign cout = cin & (q_q == ROTOR_MAX);
  assign q    = q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (step && cin) begin
      q_d = (q_q == ROTOR_MAX) ? '0 : q_q + ROTOR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) q_q <= '0;
    else         q_q <= q_d;
  end

endmodule

// File: rtl/bombe_rotor_stepper.sv
// Rotor sequencer: load, settle, test handshake, odometer step, halt.
// Ports: start/abort/init_*/test_ack/test_match in; rotor_load,
// rotor_init, rotor_inc, pos_*, test_req, busy, found, exhausted out.
// BOMBE_STEPPER_COUNT_EN adds output tested_count[14:0].
module bombe_rotor_stepper
  import bombe_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int STEP_PULSE    = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ROTOR_W-1:0]   init_fast,
  input  logic [ROTOR_W-1:0]   init_mid,
  input  logic [ROTOR_W-1:0]   init_slow,
  input  logic                 test_ack,
  input  logic                 test_match,
  output logic                 rotor_load,
  output logic [3*ROTOR_W-1:0] rotor_init,
  output logic [2:0]           rotor_inc,
  output logic [ROTOR_W-1:0]   pos_fast,
  output logic [ROTOR_W-1:0]   pos_mid,
  output logic [ROTOR_W-1:0]   pos_slow,
  output logic                 test_req,
  output logic                 busy,
  output logic                 found,
  output logic                 exhausted
`ifdef BOMBE_STEPPER_COUNT_EN
  ,
  output logic [CNT_W-1:0]     tested_count
`endif
);

  localparam int MAXC =
    (SETTLE_CYCLES > STEP_PULSE) ? SETTLE_CYCLES : STEP_PULSE;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STEP_LAST   = CW'(STEP_PULSE - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]     tested_q, tested_d;
  logic                 rotor_load_q, rotor_load_d;
  logic [3*ROTOR_W-1:0] rotor_init_q, rotor_init_d;
  logic [2:0]           rotor_inc_q, rotor_inc_d;
  logic                 test_req_q, test_req_d;
  logic                 busy_q, busy_d;
  logic                 found_q, found_d;
  logic                 exh_q, exh_d;

  logic               dig_load;
  logic               dig_step;
  logic               c_fast;
  logic               c_mid;
  logic               c_slow;
  logic [ROTOR_W-1:0] ld_fast, ld_mid, ld_slow;
  logic [2:0]         inc_pat;

  assign ld_fast = clamp_init(init_fast);
  assign ld_mid  = clamp_init(init_mid);
  assign ld_slow = clamp_init(init_slow);

  // Odometer carries from the current mirror give the inc pattern.
  assign inc_pat = {c_mid, c_fast, 1'b1};

  mod26_digit u_fast (
    .clk      (clk),
    .resetn   (resetn),
    .load     (dig_load),
    .load_val (ld_fast),
    .step     (dig_step),
    .cin      (1'b1),
    .q        (pos_fast),
    .cout     (c_fast)
  );

  mod26_digit u_mid (
    .clk      (clk),
    .resetn   (resetn),
    .load     (dig_load),
    .load_val (ld_mid),
    .step     (dig_step),
    .cin      (c_fast),
    .q        (pos_mid),
    .cout     (c_mid)
  );

  mod26_digit u_slow (
    .clk      (clk),
    .resetn   (resetn),
    .load     (dig_load),
    .load_val (ld_slow),
    .step     (dig_step),
    .cin      (c_mid),
    .q        (pos_slow),
    .cout     (c_slow)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tested_d     = tested_q;
    rotor_load_d = 1'b0;
    rotor_init_d = rotor_init_q;
    rotor_inc_d  = 3'b000;
    test_req_d   = 1'b0;
    busy_d       = 1'b0;
    found_d      = found_q;
    exh_d        = exh_q;
    dig_load     = 1'b0;
    dig_step     = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      found_d = 1'b0;
      exh_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_FOUND, ST_EXH: begin
          if (start) begin
            state_d      = ST_LOAD;
            rotor_load_d = 1'b1;
            busy_d       = 1'b1;
            rotor_init_d = {ld_slow, ld_mid, ld_fast};
            dig_load     = 1'b1;
            found_d      = 1'b0;
            exh_d        = 1'b0;
            tested_d     = '0;
          end
        end
        ST_LOAD: begin
          state_d = ST_SETTLE;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
        ST_SETTLE: begin
          busy_d = 1'b1;
          if (cnt_q == SETTLE_LAST) begin
            state_d    = ST_TEST;
            test_req_d = 1'b1;
            cnt_d      = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_TEST: begin
          busy_d = 1'b1;
          if (!test_ack) begin
            test_req_d = 1'b1;
          end else if (test_match) begin
            state_d = ST_FOUND;
            found_d = 1'b1;
            busy_d  = 1'b0;
          end else if (tested_q == LAST_IDX) begin
            // Final position: advance mirrors back onto the
            // start position without counting a new test.
            state_d  = ST_EXH;
            exh_d    = 1'b1;
            busy_d   = 1'b0;
            dig_step = 1'b1;
          end else begin
            state_d     = ST_STEP;
            rotor_inc_d = inc_pat;
            cnt_d       = '0;
          end
        end
        ST_STEP: begin
          busy_d = 1'b1;
          if (cnt_q == STEP_LAST) begin
            state_d  = ST_SETTLE;
            cnt_d    = '0;
            dig_step = 1'b1;
            tested_d = tested_q + CNT_W'(1);
          end else begin
            cnt_d       = cnt_q + CW'(1);
            rotor_inc_d = rotor_inc_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      tested_q     <= '0;
      rotor_load_q <= 1'b0;
      rotor_init_q <= '0;
      rotor_inc_q  <= 3'b000;
      test_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      found_q      <= 1'b0;
      exh_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tested_q     <= tested_d;
      rotor_load_q <= rotor_load_d;
      rotor_init_q <= rotor_init_d;
      rotor_inc_q  <= rotor_inc_d;
      test_req_q   <= test_req_d;
      busy_q       <= busy_d;
      found_q      <= found_d;
      exh_q        <= exh_d;
    end
  end

  assign rotor_load = rotor_load_q;
  assign rotor_init = rotor_init_q;
  assign rotor_inc  = rotor_inc_q;
  assign test_req   = test_req_q;
  assign busy       = busy_q;
  assign found      = found_q;
  assign exhausted  = exh_q;

`ifdef BOMBE_STEPPER_COUNT_EN
  assign tested_count = tested_q;
`endif

endmodule
